// File: rtl/cpu_pkg.sv
// Shared encodings for the fetch stage: PC-control codes, fetch FSM states and the NOP word.
package cpu_pkg;

  localparam logic [2:0] PC_NEXT   = 3'b000;
  localparam logic [2:0] PC_JUMP   = 3'b001;
  localparam logic [2:0] PC_JR     = 3'b010;
  localparam logic [2:0] PC_BRANCH = 3'b011;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the retiring instruction, with a word-alignment check.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       instr,
  input  logic [2:0]        pc_control,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] next_pc,
  output logic              misaligned
);

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] branch_offset;

  assign pc_plus4      = pc + 32'd4;
  assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    case (pc_control)
      PC_JUMP:   next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      PC_JR:     next_pc = jr_target;
      PC_BRANCH: next_pc = pc_plus4 + branch_offset;
      default:   next_pc = pc_plus4; // reserved 1xx codes fall through as sequential
    endcase
  end

  assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and redirects on retirement.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic              instr_done,
  input  logic [2:0]        pc_control,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              fault
);

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [31:0]       instr_reg, instr_next;
  logic              fault_reg, fault_next;
  logic [ADDR_W-1:0] target_pc;
  logic              target_misaligned;

  next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc_calc (
    .pc         (pc_reg),
    .instr      (instr_reg),
    .pc_control (pc_control),
    .jr_target  (jr_target),
    .next_pc    (target_pc),
    .misaligned (target_misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      pc_reg    <= RESET_PC;
      instr_reg <= NOP;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      fault_reg <= fault_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    fault_next = fault_reg;
    case (state_reg)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          instr_next = imem_rdata;
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        // stall overrides retirement; the target is only consulted on an accepted done
        if (instr_done && !stall) begin
          if (target_misaligned) begin
            fault_next = 1'b1;
            state_next = S_HALT;
          end else begin
            pc_next    = target_pc;
            state_next = S_FETCH;
          end
        end
      end
      default: state_next = S_HALT;
    endcase
  end

  // Handshake and decoder flags are pure state decodes, so rst drops them immediately.
  assign imem_req    = (state_reg == S_FETCH);
  assign instr_valid = (state_reg == S_EXEC);
  assign imem_addr   = pc_reg;
  assign pc_out      = pc_reg;
  assign pc_plus4    = pc_reg + 32'd4;
  assign instr       = instr_reg;
  assign fault       = fault_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit: expected fetch addresses and instructions are queued when driven.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_done;
  logic [2:0]  pc_control;
  logic [31:0] jr_target;
  logic        stall;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        fault;

  int tests = 0;
  int fails = 0;
  logic [31:0] addr_q[$];
  logic [31:0] instr_q[$];

  fetch_unit #(.RESET_PC(32'h0040_0000), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_done (instr_done),
    .pc_control (pc_control),
    .jr_target  (jr_target),
    .stall      (stall),
    .pc_out     (pc_out),
    .pc_plus4   (pc_plus4),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("[TB] %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Wait at negedges for a request, then compare its address with the scoreboard head.
  task automatic wait_req(input string tag);
    logic [31:0] exp;
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    exp = (addr_q.size() > 0) ? addr_q.pop_front() : 32'hDEAD_BEEF;
    if (!imem_req) begin
      tests++;
      fails++;
      $display("FAIL %s req_timeout observed=0 expected=1", tag);
    end else begin
      check(tag, imem_addr, exp);
    end
  endtask

  // Ack two cycles after the request; the instruction must be live the cycle after ack.
  task automatic do_fetch(input string tag, input logic [31:0] rdata);
    wait_req(tag);
    @(negedge clk);
    check({tag, "_req_held"}, {31'd0, imem_req}, 32'd1);
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    instr_q.push_back(rdata);
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    check({tag, "_instr"}, instr, instr_q.pop_front());
  endtask

  task automatic retire(input logic [2:0] code, input logic [31:0] jr, input logic [31:0] exp_addr);
    instr_done = 1'b1;
    pc_control = code;
    jr_target  = jr;
    addr_q.push_back(exp_addr);
    @(negedge clk);
    instr_done = 1'b0;
    pc_control = 3'b000;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; instr_done = 1'b0;
    pc_control = 3'b000; jr_target = 32'h0; stall = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req",   {31'd0, imem_req},    32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_fault", {31'd0, fault},       32'd0);
    check("rst_addr",  imem_addr,            32'h0040_0000);
    check("rst_pc4",   pc_plus4,             32'h0040_0004);
    check("rst_instr", instr,                32'h0);

    // Reset while a request is outstanding, then a late ack during idle.
    rst = 1'b0;
    @(negedge clk);
    check("mid_req_up", {31'd0, imem_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_req_drop", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = 32'h0;
    check("late_ack_valid", {31'd0, instr_valid}, 32'd0);

    // Sequential fetch.
    addr_q.push_back(32'h0040_0000);
    do_fetch("seq0", 32'h2008_0005);
    retire(3'b000, 32'h0, 32'h0040_0004);
    check("seq_req_next", {31'd0, imem_req}, 32'd1);
    do_fetch("seq1", 32'h0000_0000);

    // Ack outside fetch is ignored.
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = 32'h0;
    check("stray_ack", instr, 32'h0000_0000);

    // Backward branch at 0x400010.
    retire(3'b010, 32'h0040_0010, 32'h0040_0010);
    do_fetch("br", 32'h1000_FFFF);
    retire(3'b011, 32'h0, 32'h0040_0010);
    do_fetch("br_tgt", 32'h0000_0000);

    // Jump at 0x400020.
    retire(3'b010, 32'h0040_0020, 32'h0040_0020);
    do_fetch("jmp", 32'h0810_0008);
    check("jmp_pc4", pc_plus4, 32'h0040_0024);
    check("jmp_pc",  pc_out,   32'h0040_0020);
    retire(3'b001, 32'h0, 32'h0040_0020);
    do_fetch("jmp_tgt", 32'h0000_0000);

    // Wrap-around under stall.
    retire(3'b010, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    do_fetch("wrap", 32'h0000_0000);
    stall = 1'b1; instr_done = 1'b1; pc_control = 3'b000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_pc",  pc_out,                32'hFFFF_FFFC);
      check("stall_req", {31'd0, imem_req},     32'd0);
    end
    stall = 1'b0; instr_done = 1'b0;
    retire(3'b000, 32'h0, 32'h0000_0000);
    check("wrap_fault", {31'd0, fault}, 32'd0);
    do_fetch("wrap_tgt", 32'h0000_0000);

    // Reserved code behaves as sequential.
    retire(3'b101, 32'h0040_0200, 32'h0000_0004);
    do_fetch("rsvd", 32'h0000_0000);

    // Aligned then misaligned JR.
    retire(3'b010, 32'h0040_0100, 32'h0040_0100);
    do_fetch("jr_ok", 32'h0000_0000);
    instr_done = 1'b1; pc_control = 3'b010; jr_target = 32'h0040_0002;
    @(negedge clk);
    instr_done = 1'b0; pc_control = 3'b000;
    check("jr_fault", {31'd0, fault}, 32'd1);
    check("jr_pc",    pc_out,         32'h0040_0100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halt_req",   {31'd0, imem_req},    32'd0);
      check("halt_valid", {31'd0, instr_valid}, 32'd0);
    end

    rst = 1'b1;
    @(negedge clk);
    check("rst2_fault", {31'd0, fault}, 32'd0);
    check("rst2_addr",  imem_addr,      32'h0040_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
